// File: rtl/fire_control.sv
// fire_control: turns a fire scancode into a single one-hot create pulse
// for the lowest free bullet slot. After the pulse it waits for that bullet
// to go active, enforces a cooldown, and then requires the key to be
// released before the next shot can be taken.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for fire key, live tank and a free slot
// S_FIRE     | one-cycle create pulse to the latched slot
// S_WAIT_ACK | waiting for the chosen bullet to report active (timed)
// S_COOLDOWN | minimum spacing between accepted shots
// S_HOLD     | waiting for key release so a held key fires only once
module fire_control #(
  parameter int         NUM_BULLETS = 5,
  parameter logic [7:0] FIRE_KEY    = 8'h2C,
  parameter logic [15:0] COOLDOWN   = 16'd15,
  parameter logic [3:0] ACK_TIMEOUT = 4'd4
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [31:0]            keycode,
  input  logic                   tank_alive,
  input  logic [NUM_BULLETS-1:0] bullet_active,
  output logic [NUM_BULLETS-1:0] create,
  output logic [2:0]             slot_idx,
  output logic                   busy,
  output logic [7:0]             shot_count,
  output logic                   ack_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FIRE     = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_COOLDOWN = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;

  // The ack timer counts down to zero, so it is loaded one short of the
  // number of cycles to wait; a zero timeout still gets one cycle.
  localparam logic [3:0] ACK_LOAD = (ACK_TIMEOUT == 4'd0) ? 4'd0 : ACK_TIMEOUT - 4'd1;

  logic [2:0]  state;
  logic [3:0]  ack_cnt;
  logic [15:0] cd_cnt;
  logic        fire_pressed;
  logic [2:0]  free_slot;
  logic        have_free;
  logic [7:0]  active_pad;
  logic [7:0]  onehot;
  logic        slot_ack;

  // Fire request: any of the four scancode bytes matching the fire key.
  always_comb begin
    fire_pressed = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (keycode[k*8 +: 8] == FIRE_KEY) fire_pressed = 1'b1;
    end
  end

  // Lowest-index inactive bullet wins; scan downward so the last hit is lowest.
  always_comb begin
    free_slot = 3'd0;
    have_free = 1'b0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!bullet_active[i]) begin
        free_slot = 3'(i);
        have_free = 1'b1;
      end
    end
  end

  // Widen bullet status to 8 bits so slot_idx can index it for any slot count.
  always_comb begin
    active_pad = '0;
    active_pad[NUM_BULLETS-1:0] = bullet_active;
  end

  // One-hot decode of the slot about to be fired.
  always_comb begin
    onehot = '0;
    onehot[free_slot] = 1'b1;
  end

  assign slot_ack = active_pad[slot_idx];
  assign busy     = (state != S_IDLE);

  // Shot sequencer: state, latched slot, create pulse, counters and error flag.
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state      <= S_IDLE;
      create     <= '0;
      slot_idx   <= 3'd0;
      shot_count <= 8'd0;
      ack_err    <= 1'b0;
      ack_cnt    <= 4'd0;
      cd_cnt     <= 16'd0;
    end else begin
      create <= '0;
      case (state)
        S_IDLE: begin
          if (fire_pressed && tank_alive && have_free) begin
            state    <= S_FIRE;
            slot_idx <= free_slot;
            create   <= onehot[NUM_BULLETS-1:0];
          end
        end
        S_FIRE: begin
          shot_count <= shot_count + 8'd1;
          ack_cnt    <= ACK_LOAD;
          state      <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (slot_ack) begin
            cd_cnt <= COOLDOWN;
            state  <= S_COOLDOWN;
          end else if (ack_cnt == 4'd0) begin
            ack_err <= 1'b1;
            cd_cnt  <= COOLDOWN;
            state   <= S_COOLDOWN;
          end else begin
            ack_cnt <= ack_cnt - 4'd1;
          end
        end
        S_COOLDOWN: begin
          if (cd_cnt == 16'd0) state <= S_HOLD;
          else                 cd_cnt <= cd_cnt - 16'd1;
        end
        S_HOLD: begin
          if (!fire_pressed) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fire_control.md
FIRE_CONTROL -- requirements
Module: fire_control

Interface
REQ-001 Parameter NUM_BULLETS, default 5, number of bullet instances served (range 1-8).
REQ-002 Parameter FIRE_KEY, default 8'h2C, scancode that requests a shot.
REQ-003 Parameter COOLDOWN, default 16'd15, frames between accepted shots.
REQ-004 Parameter ACK_TIMEOUT, default 4'd4, cycles to wait for the bullet to go active.
REQ-005 frame_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Reset  in  1  synchronous, active-low reset; sampled only on the frame_clk rising edge.
REQ-007 keycode  in  32  four packed 8-bit scancodes, byte 0 = bits 7:0.
REQ-008 tank_alive  in  1  shots permitted only while high.
REQ-009 bullet_active  in  NUM_BULLETS  is_bullet_active from each bullet instance.
REQ-010 create  out  NUM_BULLETS  one-hot create pulse to the selected bullet instance.
REQ-011 slot_idx  out  3  index of the slot last fired.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 shot_count  out  8  number of create pulses issued; wraps modulo 256.
REQ-014 ack_err  out  1  sticky flag; set on ACK_TIMEOUT expiry.

Function
REQ-015 fire_pressed SHALL be the OR of (keycode byte k == FIRE_KEY) for k = 0..3, evaluated combinationally.
REQ-016 free_slot SHALL be the lowest index i with bullet_active[i] == 0; have_free SHALL be high when any such index exists.
REQ-017 States: IDLE, FIRE, WAIT_ACK, COOLDOWN, HOLD; encoding is free.
REQ-018 IDLE -> FIRE when fire_pressed && tank_alive && have_free; slot_idx SHALL latch free_slot on that edge.
REQ-019 FIRE SHALL last exactly one cycle, with create[slot_idx] = 1 and all other create bits 0; shot_count SHALL increment on the exit edge; next state is WAIT_ACK.
REQ-020 create SHALL be all-zero in every state other than FIRE.
REQ-021 WAIT_ACK -> COOLDOWN on the first cycle bullet_active[slot_idx] == 1; otherwise after ACK_TIMEOUT cycles in WAIT_ACK, set ack_err and go to COOLDOWN.
REQ-022 COOLDOWN SHALL load a 16-bit counter with COOLDOWN on entry, decrement once per cycle, and exit to HOLD on the cycle the counter reads 0; COOLDOWN = 0 gives one cycle in COOLDOWN.
REQ-023 HOLD -> IDLE on the first cycle fire_pressed == 0; a held key yields exactly one shot (no auto-fire).
REQ-024 When all bullet_active bits are 1 in IDLE with fire_pressed, the block SHALL remain in IDLE, issue no create, and fire on the first cycle a slot frees if the key is still held.
REQ-025 tank_alive low SHALL block IDLE -> FIRE only; a sequence already past IDLE completes normally.
REQ-026 A bullet_active[slot_idx] that is already 1 during FIRE (bullet re-armed elsewhere) SHALL satisfy WAIT_ACK on its first cycle.
REQ-027 Multiple bytes equal to FIRE_KEY in keycode SHALL count as a single press.
REQ-028 Latency: fire_pressed sampled high in IDLE at edge N gives create high during cycle N+1 and low at N+2.

Reset
REQ-029 Reset low at a clock edge SHALL force: state IDLE, create 0, slot_idx 0, busy 0, shot_count 0, ack_err 0, cooldown counter 0.
REQ-030 Reset asserted mid-sequence, including during FIRE, SHALL abort it on that edge; create SHALL be 0 in the following cycle.
REQ-031 After Reset release, a key already held SHALL fire on the first IDLE cycle.

Verification
REQ-032 Bench: keycode = 32'h0000002C, tank_alive = 1, bullet_active = 5'b00000 -> create = 5'b00001 for one cycle, slot_idx = 0, shot_count = 1; bullet_active[0] raised 2 cycles later -> COOLDOWN lasts 16 cycles, then HOLD.
REQ-033 Bench: bullet_active = 5'b01011, key pressed in byte 2 (32'h002C0000) -> create = 5'b00100, slot_idx = 2.
REQ-034 Bench: key held for 200 cycles with bullets free -> exactly one create pulse; release then re-press -> a second pulse, shot_count = 2.
REQ-035 Bench: bullet_active never rises after FIRE -> ack_err = 1 after 4 WAIT_ACK cycles; FSM proceeds to COOLDOWN.
REQ-036 Bench: bullet_active = 5'b11111 with key held, then bit 3 drops -> no create while all are active; create = 5'b01000 one cycle after the drop.
REQ-037 Bench: Reset = 0 asserted in COOLDOWN with shot_count = 7 -> next cycle IDLE, shot_count = 0, busy = 0, create = 0.
